// File: rtl/mem_stage_pl_if.sv
// mem_stage_pl_if: pipeline bus of the MEM stage.
//   Next*      EX/MEM inputs captured by the stage (plus Stall hold from later stages)
//   ALUOut, MEMDout, PassThru, DInSrc, RegWAddr, RegWE  writeback-side outputs
//   Valid, Busy, Misalign                                status outputs
// master: drives Next*/Stall (upstream side); slave: the MEM stage itself.
interface mem_stage_pl_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned RAW = 6,
  parameter int unsigned PTW = 70
);
  logic           Stall;
  logic           NextValid;
  logic [DW-1:0]  NextALUOut;
  logic [DW-1:0]  NextRegB;
  logic [PTW-1:0] NextPassThru;
  logic [1:0]     NextDInSrc;
  logic           NextRegWE;
  logic [RAW-1:0] NextRegWAddr;
  logic [1:0]     NextMEMSize;
  logic           NextMEMWE;
  logic           NextMEMRE;
  logic           NextExtMEM;

  logic [DW-1:0]  ALUOut;
  logic [DW-1:0]  MEMDout;
  logic [PTW-1:0] PassThru;
  logic [1:0]     DInSrc;
  logic [RAW-1:0] RegWAddr;
  logic           RegWE;
  logic           Valid;
  logic           Busy;
  logic           Misalign;

  modport master (
    output Stall, NextValid, NextALUOut, NextRegB, NextPassThru, NextDInSrc, NextRegWE,
           NextRegWAddr, NextMEMSize, NextMEMWE, NextMEMRE, NextExtMEM,
    input  ALUOut, MEMDout, PassThru, DInSrc, RegWAddr, RegWE, Valid, Busy, Misalign
  );

  modport slave (
    input  Stall, NextValid, NextALUOut, NextRegB, NextPassThru, NextDInSrc, NextRegWE,
           NextRegWAddr, NextMEMSize, NextMEMWE, NextMEMRE, NextExtMEM,
    output ALUOut, MEMDout, PassThru, DInSrc, RegWAddr, RegWE, Valid, Busy, Misalign
  );
endinterface

// File: rtl/mem_stage_pl.sv
// mem_stage_pl: MEM pipeline stage with EX/MEM register and a big-endian, byte-addressable
// data memory of configurable latency.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mem_stage_pl_if.slave: Next* inputs and Stall in; writeback outputs, Valid, Busy,
//          Misalign out
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN; otherwise Misalign
// is 0 and low offset bits are masked to the access size.
module mem_stage_pl #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned RAW   = 6,
  parameter int unsigned PTW   = 70,
  parameter int unsigned LAT   = 1
) (
  input logic          clk,
  input logic          reset,
  mem_stage_pl_if.slave bus
);
  localparam int unsigned NB   = DW / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CntInit = CW'((LAT > 1) ? (LAT - 2) : 0);

  typedef enum logic {StIdle, StWait} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           valid_q, reg_we_q, mem_we_q, mem_re_q, ext_mem_q;
  logic [DW-1:0]  alu_out_q, reg_b_q;
  logic [PTW-1:0] pass_thru_q;
  logic [1:0]     din_src_q, mem_size_q;
  logic [RAW-1:0] reg_waddr_q;

  logic [DW-1:0]  mem_q [DEPTH];

  logic busy, valid_out, load_en, next_mem_op, load_held, misalign, wr_en;
  logic [OFFW-1:0] off_raw, off_a;
  logic [AW-1:0]   word_idx;
  logic [OFFW+2:0] sh_byte, sh_half;
  logic [DW-1:0]   rd_word, rd_byte_sh, rd_half_sh, ld_ext, wdata;
  logic [NB-1:0]   be;

  assign busy        = (state_q == StWait);
  assign valid_out   = valid_q & ~busy;
  assign load_en     = ~bus.Stall & ~busy;
  assign next_mem_op = bus.NextValid & (bus.NextMEMWE | bus.NextMEMRE);

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      alu_out_q   <= '0;
      reg_b_q     <= '0;
      pass_thru_q <= '0;
      din_src_q   <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      mem_size_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      ext_mem_q   <= 1'b0;
    end else if (load_en) begin
      valid_q     <= bus.NextValid;
      alu_out_q   <= bus.NextALUOut;
      reg_b_q     <= bus.NextRegB;
      pass_thru_q <= bus.NextPassThru;
      din_src_q   <= bus.NextDInSrc;
      reg_we_q    <= bus.NextRegWE;
      reg_waddr_q <= bus.NextRegWAddr;
      mem_size_q  <= bus.NextMEMSize;
      mem_we_q    <= bus.NextMEMWE;
      mem_re_q    <= bus.NextMEMRE;
      ext_mem_q   <= bus.NextExtMEM;
    end
  end

  // Latency FSM: Busy lasts LAT-1 cycles after a memory op is captured
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (load_en && next_mem_op && (LAT > 1)) begin
          state_d = StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Addressing; offset is aligned to the access size for data steering
  assign word_idx = alu_out_q[OFFW +: AW];
  assign off_raw  = alu_out_q[OFFW-1:0];

  always_comb begin
    off_a = off_raw;
    if (mem_size_q[1])      off_a    = '0;
    else if (mem_size_q[0]) off_a[0] = 1'b0;
  end

  // Byte offset 0 is the MSB lane, so the right-shift is (NB-1-off) bytes
  assign sh_byte = {~off_a, 3'b000};
  assign sh_half = {~off_a[OFFW-1:1], 4'b0000};

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = valid_out & (mem_we_q | mem_re_q) &
                    (mem_size_q[1] ? (|off_raw) : (mem_size_q[0] & off_raw[0]));
`else
  assign misalign = 1'b0;
`endif

  // Load path
  assign rd_word    = mem_q[word_idx];
  assign rd_byte_sh = rd_word >> sh_byte;
  assign rd_half_sh = rd_word >> sh_half;
  assign load_held  = valid_q & mem_re_q & ~mem_we_q;

  always_comb begin
    if (mem_size_q[1]) begin
      ld_ext = rd_word;
    end else if (mem_size_q[0]) begin
      ld_ext = {{(DW-16){ext_mem_q & rd_half_sh[15]}}, rd_half_sh[15:0]};
    end else begin
      ld_ext = {{(DW-8){ext_mem_q & rd_byte_sh[7]}}, rd_byte_sh[7:0]};
    end
  end

  // Store path: data placed into its lane, be[k] enables byte offset k
  always_comb begin
    be = '0;
    if (mem_size_q[1]) begin
      be    = '1;
      wdata = reg_b_q;
    end else if (mem_size_q[0]) begin
      be[off_a]                  = 1'b1;
      be[{off_a[OFFW-1:1], 1'b1}] = 1'b1;
      wdata = {{(DW-16){1'b0}}, reg_b_q[15:0]} << sh_half;
    end else begin
      be[off_a] = 1'b1;
      wdata     = {{(DW-8){1'b0}}, reg_b_q[7:0]} << sh_byte;
    end
  end

  // Commits on the edge that also captures the next instruction, so it fires once
  assign wr_en = valid_q & mem_we_q & ~busy & ~bus.Stall & ~misalign;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (be[k]) mem_q[word_idx][DW-1-8*k -: 8] <= wdata[DW-1-8*k -: 8];
      end
    end
  end

  assign bus.ALUOut   = alu_out_q;
  assign bus.MEMDout  = (valid_out & load_held) ? ld_ext : '0;
  assign bus.PassThru = pass_thru_q;
  assign bus.DInSrc   = din_src_q;
  assign bus.RegWAddr = reg_waddr_q;
  assign bus.RegWE    = reg_we_q & valid_out & ~misalign;
  assign bus.Valid    = valid_out;
  assign bus.Busy     = busy;
  assign bus.Misalign = misalign;
endmodule

// File: tb/tb_mem_stage_pl.sv
module tb_mem_stage_pl;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned RAW   = 6;
  localparam int unsigned PTW   = 70;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_pl_if #(.DW(DW), .RAW(RAW), .PTW(PTW)) bus1 ();
  mem_stage_pl_if #(.DW(DW), .RAW(RAW), .PTW(PTW)) bus4 ();

  mem_stage_pl #(.DW(DW), .DEPTH(DEPTH), .RAW(RAW), .PTW(PTW), .LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );
  mem_stage_pl #(.DW(DW), .DEPTH(DEPTH), .RAW(RAW), .PTW(PTW), .LAT(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  // Stimulus, routed to the DUT selected by sel (0: LAT=1, 1: LAT=4)
  int             sel = 0;
  logic           stall = 1'b0, n_valid = 1'b0, n_rwe = 1'b0, n_we = 1'b0, n_re = 1'b0;
  logic           n_ext = 1'b0;
  logic [31:0]    n_alu = '0, n_regb = '0;
  logic [PTW-1:0] n_pt = '0;
  logic [1:0]     n_dsrc = '0, n_size = '0;
  logic [RAW-1:0] n_waddr = '0;

  assign bus1.Stall = stall & (sel == 0);
  assign bus4.Stall = stall & (sel == 1);
  assign bus1.NextValid = n_valid & (sel == 0);
  assign bus4.NextValid = n_valid & (sel == 1);
  assign bus1.NextALUOut = n_alu;     assign bus4.NextALUOut = n_alu;
  assign bus1.NextRegB = n_regb;      assign bus4.NextRegB = n_regb;
  assign bus1.NextPassThru = n_pt;    assign bus4.NextPassThru = n_pt;
  assign bus1.NextDInSrc = n_dsrc;    assign bus4.NextDInSrc = n_dsrc;
  assign bus1.NextRegWE = n_rwe;      assign bus4.NextRegWE = n_rwe;
  assign bus1.NextRegWAddr = n_waddr; assign bus4.NextRegWAddr = n_waddr;
  assign bus1.NextMEMSize = n_size;   assign bus4.NextMEMSize = n_size;
  assign bus1.NextMEMWE = n_we;       assign bus4.NextMEMWE = n_we;
  assign bus1.NextMEMRE = n_re;       assign bus4.NextMEMRE = n_re;
  assign bus1.NextExtMEM = n_ext;     assign bus4.NextExtMEM = n_ext;

  logic           o_valid, o_busy, o_rwe, o_mis;
  logic [31:0]    o_alu, o_md;
  logic [PTW-1:0] o_pt;
  logic [1:0]     o_dsrc;
  logic [RAW-1:0] o_waddr;
  assign o_valid = (sel == 0) ? bus1.Valid    : bus4.Valid;
  assign o_busy  = (sel == 0) ? bus1.Busy     : bus4.Busy;
  assign o_rwe   = (sel == 0) ? bus1.RegWE    : bus4.RegWE;
  assign o_mis   = (sel == 0) ? bus1.Misalign : bus4.Misalign;
  assign o_alu   = (sel == 0) ? bus1.ALUOut   : bus4.ALUOut;
  assign o_md    = (sel == 0) ? bus1.MEMDout  : bus4.MEMDout;
  assign o_pt    = (sel == 0) ? bus1.PassThru : bus4.PassThru;
  assign o_dsrc  = (sel == 0) ? bus1.DInSrc   : bus4.DInSrc;
  assign o_waddr = (sel == 0) ? bus1.RegWAddr : bus4.RegWAddr;

  int checks = 0;
  int errors = 0;

  // Reference memory: one byte array per DUT, byte address = word*4 + big-endian offset
  logic [7:0] mref [2][4*DEPTH];

  logic [31:0] last_md;
  logic        last_mis, last_rwe;
  int          last_busy;

  function automatic logic [31:0] mword(input int s, input int unsigned b);
    return {mref[s][b], mref[s][b+1], mref[s][b+2], mref[s][b+3]};
  endfunction

  task automatic do_op(input logic we, input logic re, input logic [1:0] size, input logic ext,
                       input logic [31:0] addr, input logic [31:0] regb, input logic rwe,
                       input logic [RAW-1:0] waddr, input string name);
    logic [95:0]    r96;
    logic [PTW-1:0] pt;
    logic [1:0]     dsrc;
    logic [63:0]    v;
    logic [31:0]    exp_md, sh;
    logic           mis, memop;
    int unsigned    nb, off, eoff, base;
    int             busy_n, guard, exp_busy;
    r96  = {$urandom, $urandom, $urandom};
    pt   = r96[PTW-1:0];
    dsrc = 2'($urandom_range(0, 3));
    nb   = size[1] ? 4 : (size[0] ? 2 : 1);
    off  = addr % 4;
    eoff = off - (off % nb);
    base = ((addr / 4) % DEPTH) * 4;
    memop = we | re;
`ifdef MEM_ALIGN_CHECK_EN
    mis = memop && ((off % nb) != 0);
`else
    mis = 1'b0;
`endif
    v = '0;
    for (int unsigned i = 0; i < nb; i++) v = (v << 8) | 64'(mref[sel][base+eoff+i]);
    if (ext && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
    exp_md = (re && !we) ? v[31:0] : 32'd0;
    if (we && !mis) begin
      for (int unsigned i = 0; i < nb; i++) begin
        sh = regb >> (8*(nb-1-i));
        mref[sel][base+eoff+i] = sh[7:0];
      end
    end
    exp_busy = (memop && sel == 1) ? 3 : 0;

    @(negedge clk);
    guard = 0;
    while (o_busy === 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_valid = 1'b1; n_we = we; n_re = re; n_size = size; n_ext = ext; n_alu = addr;
    n_regb = regb; n_rwe = rwe; n_waddr = waddr; n_pt = pt; n_dsrc = dsrc;
    @(posedge clk);
    #1;
    n_valid = 1'b0;
    busy_n = 0;
    guard = 0;
    @(negedge clk);
    while (o_busy === 1'b1 && guard < 20) begin
      busy_n++;
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("FAIL %s valid_during_busy got %b want 0", name, o_valid);
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (busy_n != exp_busy) begin
      errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, busy_n, exp_busy);
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL %s valid got %b want 1", name, o_valid);
    end
    checks++;
    if (o_alu !== addr) begin
      errors++; $display("FAIL %s aluout got %h want %h", name, o_alu, addr);
    end
    checks++;
    if (o_pt !== pt || o_dsrc !== dsrc || o_waddr !== waddr) begin
      errors++; $display("FAIL %s passthru got %h/%h/%h want %h/%h/%h", name, o_pt, o_dsrc,
                         o_waddr, pt, dsrc, waddr);
    end
    checks++;
    if (o_rwe !== (rwe & ~mis)) begin
      errors++; $display("FAIL %s regwe got %b want %b", name, o_rwe, rwe & ~mis);
    end
    checks++;
    if (o_md !== exp_md) begin
      errors++; $display("FAIL %s memdout got %h want %h", name, o_md, exp_md);
    end
    checks++;
    if (o_mis !== mis) begin
      errors++; $display("FAIL %s misalign got %b want %b", name, o_mis, mis);
    end
    last_md = o_md; last_mis = o_mis; last_rwe = o_rwe; last_busy = busy_n;
  endtask

  task automatic check_idle_outputs(input string name);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_rwe !== 1'b0 || o_mis !== 1'b0) begin
        errors++; $display("FAIL %s flags dut%0d got v%b b%b w%b m%b want 0", name, s, o_valid,
                           o_busy, o_rwe, o_mis);
      end
      checks++;
      if (o_alu !== '0 || o_md !== '0 || o_pt !== '0 || o_dsrc !== '0 || o_waddr !== '0) begin
        errors++; $display("FAIL %s data dut%0d got %h %h %h %h %h want 0", name, s, o_alu, o_md,
                           o_pt, o_dsrc, o_waddr);
      end
    end
    sel = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");
    sel = 0;
    do_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 1'b1, 6'd5, "nonmem");
  endtask

  task automatic test_init();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int w = 0; w < 32; w++) begin
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'(w * 4), $urandom, 1'b0, 6'd0, "init");
      end
    end
  endtask

  task automatic test_lat1_byte();
    sel = 0;
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 6'd0, "st_deadbeef");
    do_op(1'b0, 1'b1, 2'b00, 1'b1, 32'h11, 32'h0, 1'b1, 6'd3, "lb_sext");
    checks++;
    if (last_md !== 32'hFFFFFFAD) begin
      errors++; $display("FAIL lb_sext_const got %h want FFFFFFAD", last_md);
    end
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1, 6'd3, "lb_zext");
    checks++;
    if (last_md !== 32'h000000AD) begin
      errors++; $display("FAIL lb_zext_const got %h want 000000AD", last_md);
    end
  endtask

  task automatic test_lat4_load();
    sel = 1;
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, 6'd7, "lat4_lw");
    checks++;
    if (last_busy != 3) begin
      errors++; $display("FAIL lat4_busy_len got %0d want 3", last_busy);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d, oldw;
    sel = 0;
    d = $urandom;
    oldw = mword(0, 64);
    @(negedge clk);
    n_valid = 1'b1; n_we = 1'b1; n_re = 1'b0; n_size = 2'b10; n_alu = 32'h40; n_regb = d;
    n_rwe = 1'b0;
    @(posedge clk);
    #1;
    n_valid = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b1 || o_alu !== 32'h40) begin
        errors++; $display("FAIL stall_hold got v%b a%h want v1 a00000040", o_valid, o_alu);
      end
      checks++;
      if (u_dut1.mem_q[16] !== oldw) begin
        errors++; $display("FAIL stall_no_write got %h want %h", u_dut1.mem_q[16], oldw);
      end
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    {mref[0][64], mref[0][65], mref[0][66], mref[0][67]} = d;
    checks++;
    if (u_dut1.mem_q[16] !== d) begin
      errors++; $display("FAIL stall_commit got %h want %h", u_dut1.mem_q[16], d);
    end
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stall = 1'b0;
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 6'd1, "stall_rd");
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h44, 32'h0, 1'b1, 6'd2, "stall_adj");
  endtask

  task automatic test_wrap_reset();
    logic [31:0] d1, d2, waddr_wrap;
    sel = 1;
    waddr_wrap = 32'(4 * DEPTH + 8);
    d1 = $urandom;
    d2 = ~d1;
    do_op(1'b1, 1'b0, 2'b10, 1'b0, waddr_wrap, d1, 1'b0, 6'd0, "wrap_st");
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1, 6'd9, "wrap_ld");
    checks++;
    if (last_md !== d1) begin
      errors++; $display("FAIL wrap_const got %h want %h", last_md, d1);
    end
    @(negedge clk);
    n_valid = 1'b1; n_we = 1'b1; n_re = 1'b0; n_size = 2'b10; n_alu = waddr_wrap; n_regb = d2;
    @(posedge clk);
    #1;
    n_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL rst_wait_busy got %b want 1", o_busy);
    end
    reset = 1'b0;
    #2;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async got b%b v%b want 0 0", o_busy, o_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (u_dut4.mem_q[2] !== d1) begin
      errors++; $display("FAIL rst_drop_store got %h want %h", u_dut4.mem_q[2], d1);
    end
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, 6'd0, "rst_ld");
  endtask

  task automatic test_misalign();
    logic [31:0] oldw;
    sel = 0;
    oldw = mword(0, 32);
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0000A5B6, 1'b1, 6'd4, "sh_21");
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 6'd4, "sh_21_rd");
`ifdef MEM_ALIGN_CHECK_EN
    checks++;
    if (last_md !== oldw) begin
      errors++; $display("FAIL misalign_nowrite got %h want %h", last_md, oldw);
    end
`else
    checks++;
    if (last_md !== {16'hA5B6, oldw[15:0]}) begin
      errors++; $display("FAIL masked_half got %h want %h", last_md, {16'hA5B6, oldw[15:0]});
    end
`endif
  endtask

  task automatic test_random();
    logic [1:0] sz;
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      do_op(1'($urandom), 1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 127)),
            $urandom, 1'($urandom), 6'($urandom_range(0, 63)), "random");
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_init();
    test_lat1_byte();
    test_lat4_load();
    test_stall();
    test_wrap_reset();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_pl.md
Name: mem_stage_pl

Overview:
- Parametrised successor of the MEM pipeline stage.
- Holds the EX/MEM pipeline register and an internal big-endian, byte-addressable data memory with configurable access latency.
- Generates Busy to stall upstream while a multi-cycle access completes.
- Forwards ALU result, load data and a generic pass-through bus to writeback.

Parameters:
- DW, 32, data and address width in bits; must be 32 or 64.
- DEPTH, 1024, data memory depth in DW-bit words; must be a power of 2.
- RAW, 6, register write address width.
- PTW, 70, width of the pass-through bus (PC+4, opcode, funct, immediate, FPU result, ...).
- LAT, 1, memory access latency in cycles; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  external hold from a later stage.
- NextValid  in  1  incoming instruction is valid.
- NextALUOut  in  DW  ALU result; byte address for memory ops.
- NextRegB  in  DW  store data.
- NextPassThru  in  PTW  carried unchanged to PassThru.
- NextDInSrc  in  2  writeback source select.
- NextRegWE  in  1  register write enable.
- NextRegWAddr  in  RAW  destination register.
- NextMEMSize  in  2  00 byte, 01 half, 1x word.
- NextMEMWE  in  1  store.
- NextMEMRE  in  1  load.
- NextExtMEM  in  1  1 = sign-extend loads, 0 = zero-extend.
- ALUOut  out  DW  registered ALU result.
- MEMDout  out  DW  load data, extended.
- PassThru  out  PTW  registered pass-through bus.
- DInSrc  out  2  registered writeback source select.
- RegWAddr  out  RAW  registered destination register.
- RegWE  out  1  qualified register write enable.
- Valid  out  1  stage holds a completed valid op.
- Busy  out  1  multi-cycle access in progress; upstream must hold.
- Misalign  out  1  misaligned access flag (see Optional Feature).

Behaviour:
- Reset (reset=0, async): all pipeline registers 0, FSM to IDLE, counter 0. Every output reads 0 (MEMDout is 0 because the valid bit is 0). Memory contents are not reset.
- Register load: on a rising edge with Stall=0 and Busy=0, all Next* inputs are captured. Otherwise the register holds.
- A memory op is valid & (MEMWE | MEMRE). MEMWE and MEMRE both set is treated as a store only.
- FSM states IDLE and WAIT.
  - IDLE to WAIT: a memory op is captured and LAT>1. On that edge cnt is set to LAT-2.
  - In WAIT: if cnt==0, go to IDLE; otherwise decrement cnt.
  - Busy = (state==WAIT), so Busy is high for exactly LAT-1 cycles after capture.
  - The counter runs regardless of Stall.
  - For LAT=1, the FSM never leaves IDLE.
- Valid = valid_reg & ~Busy.
- RegWE = reg_we_reg & Valid.
- Addressing:
  - Word index = ALUOut[log2(DW/8) +: log2(DEPTH)]; higher address bits are ignored, so addresses wrap modulo DEPTH words.
  - Byte offset 0 is the most significant byte (big-endian).
- Loads:
  - MEMDout is combinational from the array, valid while Valid=1 and a load is held.
  - The selected byte or half is right-justified, then sign- or zero-extended per ExtMEM.
  - MEMDout reads 0 when no load is held.
- Stores:
  - Byte enables are derived from size and offset. A half store writes bytes at offset&~1. A word store writes the whole word.
  - The write commits exactly once, on the first rising edge where a store is held, Busy=0 and Stall=0.
  - That edge is the same one on which the next instruction is captured.
- Stall held high: the pipeline register and the memory are both frozen. Re-asserting Stall never causes a duplicate write.
- Reset asserted mid-WAIT: the FSM returns to IDLE, the in-flight store is dropped, and the array is unchanged.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined, an access is misaligned if it is a half with offset bit 0 set, or a word with any offset bit set.
  - A misaligned op sets Misalign=1 while it is held and Valid=1.
  - A misaligned store does not write memory.
  - RegWE is forced to 0 for the misaligned op.
- When undefined, Misalign is tied to 0 and the low offset bits are forced aligned (masked).

Test Plan:
- Reset released, no inputs: all outputs 0, Busy=0; then a non-memory op (ALUOut=0x1234, RegWE=1, RegWAddr=5) appears one cycle later with Valid=1 and RegWE=1.
- LAT=1, store word 0xDEADBEEF at 0x10, then load byte from 0x11 with ExtMEM=1: MEMDout=0xFFFFFFAD; with ExtMEM=0: 0x000000AD.
- LAT=4, load issued: Busy high for exactly 3 cycles and upstream held; MEMDout and Valid assert on the 4th cycle.
- Store with Stall held high for 3 cycles: memory is written once, after Stall drops; a read-back returns the data, and an adjacent word is unchanged.
- Address 4*DEPTH+8 accesses the same word as address 8 (wrap); reset pulsed during a LAT=4 store leaves that word unchanged.
- With MEM_ALIGN_CHECK_EN defined, store half at 0x21: Misalign=1, RegWE=0, memory unchanged. Without the macro, the same store writes 0x20–0x21.
